// File: rtl/mem_responder_pkg.sv
// mem_responder shared types
// FSM state and operation encodings
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder request/response bus
// master = control FSM / loader side, slave = responder
interface mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              mem_ready;
  logic              busy;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    output load_en, load_addr, load_data,
    input  rdata, mem_ready, busy, err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    input  load_en, load_addr, load_data,
    output rdata, mem_ready, busy, err
  );
endinterface

// File: rtl/mem_array.sv
// mem_responder storage
// single write port, combinational read, no reset
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // synchronous write
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory responder
// answers MemRead/MemWrite strobes after LATENCY wait cycles
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2
) (
  input logic        clock,
  input logic        reset,
  mem_responder_if.slave bus
);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state;
  state_t            state_n;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ram_q;
  logic [3:0]        cnt;
  logic              err_q;

  logic              idle;
  logic              req;
  logic              last;
  logic              cpu_we;
  logic              ld_we;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_wa;
  logic [DATA_W-1:0] ram_wd;

  // the unused code 2'd3 behaves as IDLE
  assign idle   = (state != WAIT) && (state != RESP);
  assign req    = bus.mem_read | bus.mem_write;
  assign last   = (state == WAIT) && (cnt == 4'd0);
  assign cpu_we = last && (op_q == OP_WR);
  assign ld_we  = idle && bus.load_en && !req;

  // CPU commit and preload share one port; never both
  assign ram_we = cpu_we | ld_we;
  assign ram_wa = cpu_we ? addr_q  : bus.load_addr;
  assign ram_wd = cpu_we ? wdata_q : bus.load_data;

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clock(clock),
    .we   (ram_we),
    .waddr(ram_wa),
    .wdata(ram_wd),
    .raddr(addr_q),
    .rdata(ram_q)
  );

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req) state_n = WAIT;
      WAIT:    if (cnt == 4'd0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = req ? WAIT : IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    bus.mem_ready = (state == RESP);
    bus.busy      = !idle;
  end

  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

  // request capture, wait counter and read-data register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_RD;
      cnt     <= 4'd0;
      rdata_q <= '0;
    end else begin
      if (idle && req) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        op_q    <= bus.mem_write ? OP_WR : OP_RD;
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (last && op_q == OP_RD) rdata_q <= ram_q;
    end
  end

  // sticky protocol error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      if (idle && bus.mem_read && bus.mem_write) err_q <= 1'b1;
      if (idle && bus.load_en && req)            err_q <= 1'b1;
      if (!idle && bus.load_en)                  err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// mem_responder bench: random traffic vs array model
// scoreboard queue checked by a negedge monitor
module tb_mem_responder;
  localparam int LAT = 2;

  typedef struct {
    int data;
    int cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t sb[$];
  int   ref_mem [256];
  int   ref_rdata = 0;
  int   ref_err = 0;

  mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  mem_responder_if #(.ADDR_W(8), .DATA_W(8)) ifs1 ();
  mem_responder_if #(.ADDR_W(8), .DATA_W(8)) ifs15 ();

  mem_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  mem_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .bus(ifs1)
  );
  mem_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(15)) dut15 (
    .clock(clock), .reset(reset), .bus(ifs15)
  );

  logic       rd1 = 1'b0;
  logic       rd15 = 1'b0;
  logic       sld = 1'b0;
  logic [7:0] sld_a = 8'h00;
  logic [7:0] sld_d = 8'h00;

  assign ifs1.mem_read   = rd1;
  assign ifs1.mem_write  = 1'b0;
  assign ifs1.addr       = 8'h30;
  assign ifs1.wdata      = 8'h00;
  assign ifs1.load_en    = sld;
  assign ifs1.load_addr  = sld_a;
  assign ifs1.load_data  = sld_d;
  assign ifs15.mem_read  = rd15;
  assign ifs15.mem_write = 1'b0;
  assign ifs15.addr      = 8'h30;
  assign ifs15.wdata     = 8'h00;
  assign ifs15.load_en   = sld;
  assign ifs15.load_addr = sld_a;
  assign ifs15.load_data = sld_d;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // monitor: every mem_ready pulse must match the oldest expectation
  always @(negedge clock) begin
    if (!reset && bus.mem_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ready: got ready with no request");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", int'(bus.rdata), e.data);
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_load(input int a, input int d);
    @(posedge clock) #1;
    bus.load_en = 1'b1;
    bus.load_addr = 8'(a);
    bus.load_data = 8'(d);
    ref_mem[a] = d;
    @(posedge clock) #1;
    bus.load_en = 1'b0;
  endtask

  // op: 0 read, 1 write, 2 both strobes
  // coll: 0 none, 1 load during WAIT, 2 load with strobe
  task automatic do_access(input int op, input int a, input int d,
                           input int coll);
    exp_t e;
    bit   seen;
    @(posedge clock) #1;
    bus.mem_read  = (op != 1);
    bus.mem_write = (op != 0);
    bus.addr  = 8'(a);
    bus.wdata = 8'(d);
    if (op == 0) begin
      ref_rdata = ref_mem[a];
    end else begin
      ref_mem[a] = d;
    end
    if (op == 2 || coll != 0) ref_err = 1;
    if (coll == 2) begin
      bus.load_en = 1'b1;
      bus.load_addr = 8'(a ^ 1);
      bus.load_data = 8'hEE;
    end
    e.data = ref_rdata;
    e.cyc  = cyc + LAT + 1;
    sb.push_back(e);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      chk("busy", int'(bus.busy), (k > 0) ? 1 : 0);
      if (bus.mem_ready) begin
        seen = 1;
        break;
      end
      if (k == 0) bus.load_en = 1'b0;
      if (k >= 1) begin
        bus.addr  = 8'($urandom);
        bus.wdata = 8'($urandom);
      end
      if (coll == 1 && k == 1) begin
        bus.load_en = 1'b1;
        bus.load_addr = 8'(a ^ 1);
        bus.load_data = 8'hEE;
      end
      if (coll == 1 && k == 2) bus.load_en = 1'b0;
    end
    chk("ready_seen", int'(seen), 1);
    @(posedge clock) #1;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.load_en = 1'b0;
    if (!seen) sb.delete();
  endtask

  function automatic int s_rdy(input int w);
    return w != 0 ? int'(ifs15.mem_ready) : int'(ifs1.mem_ready);
  endfunction

  function automatic int s_busy(input int w);
    return w != 0 ? int'(ifs15.busy) : int'(ifs1.busy);
  endfunction

  function automatic int s_rdata(input int w);
    return w != 0 ? int'(ifs15.rdata) : int'(ifs1.rdata);
  endfunction

  task automatic sweep(input int w, input int l);
    int start;
    int got;
    int bad;
    @(posedge clock) #1;
    if (w != 0) rd15 = 1'b1;
    else rd1 = 1'b1;
    start = cyc;
    got = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (s_rdy(w) != 0) begin
        got = cyc - start;
        break;
      end
    end
    chk(w != 0 ? "lat15_cycles" : "lat1_cycles", got, l + 1);
    chk(w != 0 ? "lat15_rdata" : "lat1_rdata", s_rdata(w), 'h5A);
    @(posedge clock) #1;
    if (w != 0) rd15 = 1'b0;
    else rd1 = 1'b0;
    @(negedge clock);
    chk(w != 0 ? "lat15_pulse" : "lat1_pulse", s_rdy(w), 0);
    bad = 0;
    repeat (l + 4) begin
      @(negedge clock);
      if (s_rdy(w) != 0 || s_busy(w) != 0) bad = 1;
    end
    chk(w != 0 ? "lat15_retrig" : "lat1_retrig", bad, 0);
  endtask

  initial begin
    int r;
    int a;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr = 8'h00;
    bus.wdata = 8'h00;
    bus.load_en = 1'b0;
    bus.load_addr = 8'h00;
    bus.load_data = 8'h00;

    repeat (2) @(negedge clock);
    chk("rst_rdata", int'(bus.rdata), 0);
    chk("rst_ready", int'(bus.mem_ready), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_err", int'(bus.err), 0);
    @(posedge clock) #1;
    reset = 1'b0;

    for (int i = 0; i < 256; i++) do_load(i, 0);
    do_load('h10, 'hA5);
    do_load('h05, 'h42);

    do_access(0, 'h10, 0, 0);
    chk("err_after_read", int'(bus.err), 0);
    do_access(1, 'hFF, 'h3C, 0);
    do_access(0, 'hFF, 0, 0);

    do_access(2, 'h00, 'h77, 0);
    chk("err_both", int'(bus.err), 1);
    do_access(0, 'h00, 0, 0);
    chk("err_sticky", int'(bus.err), 1);

    @(posedge clock) #1;
    bus.mem_write = 1'b1;
    bus.addr = 8'h05;
    bus.wdata = 8'h99;
    @(posedge clock) #1;
    reset = 1'b1;
    bus.mem_write = 1'b0;
    @(negedge clock);
    chk("mid_rst_rdata", int'(bus.rdata), 0);
    chk("mid_rst_ready", int'(bus.mem_ready), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_err", int'(bus.err), 0);
    ref_rdata = 0;
    ref_err = 0;
    @(posedge clock) #1;
    reset = 1'b0;
    do_access(0, 'h05, 0, 0);

    do_access(0, 'h21, 0, 1);
    chk("err_coll_wait", int'(bus.err), 1);
    do_access(0, 'h20, 0, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0)
        a = ($urandom_range(0, 1) != 0) ? 'hFF : 0;
      else
        a = $urandom_range(0, 255);
      if (r <= 2)      do_load(a, $urandom_range(0, 255));
      else if (r <= 5) do_access(0, a, 0, 0);
      else if (r <= 8) do_access(1, a, $urandom_range(0, 255), 0);
      else             do_access(2, a, $urandom_range(0, 255),
                                 $urandom_range(0, 2));
    end
    chk("err_final", int'(bus.err), ref_err);
    chk("sb_empty", sb.size(), 0);

    @(posedge clock) #1;
    sld = 1'b1;
    sld_a = 8'h30;
    sld_d = 8'h5A;
    @(posedge clock) #1;
    sld = 1'b0;
    fork
      sweep(0, 1);
      sweep(1, 15);
    join
    chk("lat1_err", int'(ifs1.err), 0);
    chk("lat15_err", int'(ifs15.err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle processor's control FSM. The FSM issues MemRead/MemWrite strobes; this block answers them.
- Serves requests from an internal 2^ADDR_W x DATA_W RAM.
- Inserts a parameterised number of wait states, then returns read data together with a one-cycle mem_ready pulse.
- A side-band load port lets a bench or boot loader preload program/data memory while the responder is idle.

Parameters:
- ADDR_W, 8, address width; RAM depth is 2^ADDR_W.
- DATA_W, 8, data word width.
- LATENCY, 2, number of WAIT cycles per access; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- mem_read  in  1  read request strobe from the control FSM.
- mem_write  in  1  write request strobe from the control FSM.
- addr  in  ADDR_W  request address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data, registered.
- mem_ready  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state != IDLE.
- load_en  in  1  preload write enable.
- load_addr  in  ADDR_W  preload address.
- load_data  in  DATA_W  preload data.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clock.
- Reset values: state=IDLE, rdata=0, mem_ready=0, busy=0, err=0, counter=0.
- RAM contents are not cleared by reset.
- Reset asserted mid-transaction aborts the transaction. A pending write is discarded and the RAM is unchanged.

State machine (states IDLE, WAIT, RESP):
- IDLE, with mem_read or mem_write high at the clock edge:
  - capture addr, wdata and op;
  - load counter = LATENCY-1;
  - go to WAIT.
- IDLE, both strobes high: op = write, err set.
- WAIT: counter decrements each cycle. When counter==0, go to RESP on the next edge.
- The same edge that enters RESP:
  - write op: commits mem[addr_q] = wdata_q;
  - read op: loads rdata = mem[addr_q].
- RESP: mem_ready=1 for exactly this one cycle, then IDLE unconditionally.
- Outputs mem_ready and busy are Moore outputs, decoded from state.

Latency and timing:
- Strobe first sampled at the end of cycle 0 → WAIT for cycles 1..LATENCY → mem_ready in cycle LATENCY+1.
- Back-to-back accesses cost LATENCY+2 cycles each.
- rdata holds its value until the next read completes. Writes do not disturb rdata.

Handshake rules:
- The initiator holds strobe, addr and wdata stable until it sees mem_ready, and drops the strobe in the cycle after mem_ready.
- Strobes arriving while in WAIT or RESP are ignored. The captured copies are used, so changes to addr/wdata during WAIT have no effect.

Load port:
- Honoured only in IDLE with both strobes low: mem[load_addr] = load_data at that edge, with no state change.
- load_en in IDLE together with a strobe: the CPU request wins, the load is dropped, err is set.
- load_en while busy: the load is dropped and err is set.

err:
- Sticky; cleared only by reset.

Addressing:
- addr is full width, so there is no out-of-range case.
- Addresses 0 and 2^ADDR_W-1 are both ordinary locations.

Decomposition:
- Shared package mem_responder_pkg:
  - state encoding IDLE=2'd0, WAIT=2'd1, RESP=2'd2 (2'd3 decodes to IDLE);
  - op encoding OP_RD=1'b0, OP_WR=1'b1.
- Sub-module mem_array: synchronous-write, combinational-read RAM with ADDR_W/DATA_W parameters and one write port.
- The write port is muxed between the committed CPU write and the load port. The responder arbitrates, so the two are never simultaneous.

Test Plan:
- Preload then read: load mem[0x10]=0xA5 in IDLE, then mem_read addr=0x10, LATENCY=2 → mem_ready in cycle 3 after the strobe, rdata=0xA5, busy high cycles 1-3, err=0.
- Write then read: mem_write addr=0xFF wdata=0x3C, then mem_read addr=0xFF → second mem_ready carries rdata=0x3C; rdata stays unchanged across the write.
- Both strobes: mem_read=mem_write=1, addr=0x00, wdata=0x77 → treated as write, err=1 stays set, a later read of 0x00 returns 0x77.
- Load collision: load_en with load_addr=0x20 load_data=0x11, issued during WAIT → mem[0x20] unchanged (old value 0x00 reads back), err=1.
- Reset mid-write: mem_write addr=0x05 wdata=0x99, reset asserted in WAIT → outputs at reset values immediately, mem[0x05] keeps its prior value 0x42.
- Latency sweep with LATENCY=1 and LATENCY=15, reading preloaded 0x5A → mem_ready exactly LATENCY+1 cycles after the strobe, single-cycle pulse, no retrigger when the strobe drops in the cycle after ready.
